// File: rtl/reg_file_pkg.sv
// Shared definitions for the register file and its pending-write scoreboard.
//   DATA_W_DEF / ADDR_W_DEF : default data and index widths
//   REG_ZERO                : index of the optionally hardwired zero register
//   reg_idx_t / reg_data_t  : index and data types at the default widths
//   idx_valid()             : true when an index names a real, writable register
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int unsigned REG_ZERO = 0;

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

    // An index is usable if it is implemented and is not the suppressed zero register.
    function automatic logic idx_valid(input int unsigned idx,
                                       input int unsigned num_regs,
                                       input bit          zero_reg);
        return (idx < num_regs) && !(zero_reg && (idx == REG_ZERO));
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard for decode-stage hazard detection.
//   clk, rst_n                : clock, asynchronous active-low reset
//   i_we_1/i_wa_1, i_we_2/i_wa_2 : writeback enables and indices (clear pending)
//   i_claim/i_claim_reg       : issue-time claim of a destination (sets pending)
//   i_rd_1, i_rd_2            : read indices to look up
//   o_busy_1, o_busy_2        : read index has an outstanding write
//   o_pending_cnt             : number of pending registers
module reg_scoreboard import reg_file_pkg::*; #(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = 32,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we_1,
    input  logic [ADDR_W-1:0] i_wa_1,
    input  logic              i_we_2,
    input  logic [ADDR_W-1:0] i_wa_2,
    input  logic              i_claim,
    input  logic [ADDR_W-1:0] i_claim_reg,
    input  logic [ADDR_W-1:0] i_rd_1,
    input  logic [ADDR_W-1:0] i_rd_2,
    output logic              o_busy_1,
    output logic              o_busy_2,
    output logic [ADDR_W:0]   o_pending_cnt
);

    logic [NUM_REGS-1:0] r_pending;
    logic [ADDR_W:0]     r_cnt;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;
    logic [ADDR_W:0]     w_n_added;
    logic [ADDR_W:0]     w_n_cleared;
    logic                w_hit_1;
    logic                w_hit_2;

    function automatic logic pend_at(input logic [ADDR_W-1:0]   idx,
                                     input logic [NUM_REGS-1:0] pend);
        logic v;
        v = 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
            if (idx == ADDR_W'(i)) v = pend[i];
        return v;
    endfunction

    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_claim && idx_valid(32'(i_claim_reg), NUM_REGS, ZERO_REG)
                && (i_claim_reg == ADDR_W'(i)))
                w_set[i] = 1'b1;
            if (i_we_1 && idx_valid(32'(i_wa_1), NUM_REGS, ZERO_REG) && (i_wa_1 == ADDR_W'(i)))
                w_clr[i] = 1'b1;
            if (i_we_2 && idx_valid(32'(i_wa_2), NUM_REGS, ZERO_REG) && (i_wa_2 == ADDR_W'(i)))
                w_clr[i] = 1'b1;
        end
    end

    // Count only real transitions so the counter tracks the popcount exactly:
    // a claim on an already-pending bit adds nothing, and a clear that loses
    // to a same-cycle claim removes nothing.
    always_comb begin
        w_n_added   = '0;
        w_n_cleared = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_n_added   = w_n_added   + (ADDR_W+1)'(w_set[i] & ~r_pending[i]);
            w_n_cleared = w_n_cleared + (ADDR_W+1)'(r_pending[i] & w_clr[i] & ~w_set[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_cnt     <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
            r_cnt     <= r_cnt + w_n_added - w_n_cleared;
        end
    end

    // With bypass the reader gets the value this cycle, so the hazard is gone.
    always_comb begin
        w_hit_1  = (i_we_1 && (i_wa_1 == i_rd_1)) || (i_we_2 && (i_wa_2 == i_rd_1));
        w_hit_2  = (i_we_1 && (i_wa_1 == i_rd_2)) || (i_we_2 && (i_wa_2 == i_rd_2));
        o_busy_1 = pend_at(i_rd_1, r_pending) && !(BYPASS && w_hit_1);
        o_busy_2 = pend_at(i_rd_2, r_pending) && !(BYPASS && w_hit_2);
    end

    assign o_pending_cnt = r_cnt;

endmodule

// File: rtl/reg_file_sb.sv
// Two-read / two-write register file with optional bypass, optional hardwired
// register 0 and a pending-write scoreboard.
//   clk, rst_n                          : clock, asynchronous active-low reset
//   RegWrite/write_reg/write_data       : write port 1 (ALU writeback)
//   RegWrite_2/write_reg_2/write_data_2 : write port 2 (load writeback, wins on conflict)
//   read_reg_1/2 -> read_data_1/2       : combinational read ports
//   claim/claim_reg                     : mark a destination pending at issue
//   busy_1/2                            : read index has an outstanding write
//   pending_cnt                         : number of pending registers
module reg_file_sb import reg_file_pkg::*; #(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = 32,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              RegWrite_2,
    input  logic [ADDR_W-1:0] write_reg_2,
    input  logic [DATA_W-1:0] write_data_2,
    input  logic [ADDR_W-1:0] read_reg_1,
    input  logic [ADDR_W-1:0] read_reg_2,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    input  logic              claim,
    input  logic [ADDR_W-1:0] claim_reg,
    output logic              busy_1,
    output logic              busy_2,
    output logic [ADDR_W:0]   pending_cnt
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_ok_1;
    logic              w_ok_2;
    logic [DATA_W-1:0] w_stored_1;
    logic [DATA_W-1:0] w_stored_2;

    assign w_ok_1 = RegWrite   && idx_valid(32'(write_reg),   NUM_REGS, ZERO_REG);
    assign w_ok_2 = RegWrite_2 && idx_valid(32'(write_reg_2), NUM_REGS, ZERO_REG);

    // Port 2 is checked first so it wins when both ports target one register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_ok_2 && (write_reg_2 == ADDR_W'(i)))
                    r_regs[i] <= write_data_2;
                else if (w_ok_1 && (write_reg == ADDR_W'(i)))
                    r_regs[i] <= write_data;
            end
        end
    end

    always_comb begin
        w_stored_1 = '0;
        w_stored_2 = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (read_reg_1 == ADDR_W'(i)) w_stored_1 = r_regs[i];
            if (read_reg_2 == ADDR_W'(i)) w_stored_2 = r_regs[i];
        end
    end

    // Reads are held at 0 during reset, even if a write is being bypassed.
    function automatic logic [DATA_W-1:0] read_sel(input logic              rst_ok,
                                                   input logic [ADDR_W-1:0] idx,
                                                   input logic [DATA_W-1:0] stored);
        if (!rst_ok || !idx_valid(32'(idx), NUM_REGS, ZERO_REG)) return '0;
        if (BYPASS && RegWrite_2 && (write_reg_2 == idx)) return write_data_2;
        if (BYPASS && RegWrite && (write_reg == idx)) return write_data;
        return stored;
    endfunction

    assign read_data_1 = read_sel(rst_n, read_reg_1, w_stored_1);
    assign read_data_2 = read_sel(rst_n, read_reg_2, w_stored_2);

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_sb (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_we_1        (RegWrite),
        .i_wa_1        (write_reg),
        .i_we_2        (RegWrite_2),
        .i_wa_2        (write_reg_2),
        .i_claim       (claim),
        .i_claim_reg   (claim_reg),
        .i_rd_1        (read_reg_1),
        .i_rd_2        (read_reg_2),
        .o_busy_1      (busy_1),
        .o_busy_2      (busy_2),
        .o_pending_cnt (pending_cnt)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two instances (bypass on / off) driven by the same
// inputs, checked against a directed table and a behavioural model.
module tb_reg_file_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 16;

    logic          clk;
    logic          rst_n;
    logic          we1, we2, cl;
    logic [AW-1:0] wa1, wa2, cr, rr1, rr2;
    logic [DW-1:0] d1, d2;
    logic [DW-1:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic          a_b1, a_b2, b_b1, b_b2;
    logic [AW:0]   a_cnt, b_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .RegWrite(we1), .write_reg(wa1), .write_data(d1),
        .RegWrite_2(we2), .write_reg_2(wa2), .write_data_2(d2),
        .read_reg_1(rr1), .read_reg_2(rr2), .read_data_1(a_rd1), .read_data_2(a_rd2),
        .claim(cl), .claim_reg(cr), .busy_1(a_b1), .busy_2(a_b2), .pending_cnt(a_cnt));

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .RegWrite(we1), .write_reg(wa1), .write_data(d1),
        .RegWrite_2(we2), .write_reg_2(wa2), .write_data_2(d2),
        .read_reg_1(rr1), .read_reg_2(rr2), .read_data_1(b_rd1), .read_data_2(b_rd2),
        .claim(cl), .claim_reg(cr), .busy_1(b_b1), .busy_2(b_b2), .pending_cnt(b_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [DW-1:0] m_regs [NR];
    bit            m_pend [NR];

    function automatic bit m_ok(int idx);
        return (idx > 0) && (idx < NR);
    endfunction

    function automatic logic [31:0] m_read(int idx, bit byp);
        if (!m_ok(idx)) return 32'd0;
        if (byp && we2 && (int'(wa2) == idx)) return d2;
        if (byp && we1 && (int'(wa1) == idx)) return d1;
        return m_regs[idx];
    endfunction

    function automatic bit m_busy(int idx, bit byp);
        if (!m_ok(idx)) return 1'b0;
        if (byp && ((we2 && (int'(wa2) == idx)) || (we1 && (int'(wa1) == idx)))) return 1'b0;
        return m_pend[idx];
    endfunction

    function automatic int m_cnt();
        int c = 0;
        foreach (m_pend[i]) c += int'(m_pend[i]);
        return c;
    endfunction

    task automatic m_reset();
        foreach (m_regs[i]) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic m_update();
        if (we1 && m_ok(int'(wa1))) m_regs[int'(wa1)] = d1;
        if (we2 && m_ok(int'(wa2))) m_regs[int'(wa2)] = d2;
        if (we1 && m_ok(int'(wa1))) m_pend[int'(wa1)] = 1'b0;
        if (we2 && m_ok(int'(wa2))) m_pend[int'(wa2)] = 1'b0;
        if (cl && m_ok(int'(cr))) m_pend[int'(cr)] = 1'b1;
    endtask

    task automatic check_model(input string tg);
        chk({tg, " A.rd1"},  a_rd1,          m_read(int'(rr1), 1'b1));
        chk({tg, " A.rd2"},  a_rd2,          m_read(int'(rr2), 1'b1));
        chk({tg, " A.busy1"}, 32'(a_b1),     32'(m_busy(int'(rr1), 1'b1)));
        chk({tg, " A.busy2"}, 32'(a_b2),     32'(m_busy(int'(rr2), 1'b1)));
        chk({tg, " A.cnt"},  32'(a_cnt),     32'(m_cnt()));
        chk({tg, " B.rd1"},  b_rd1,          m_read(int'(rr1), 1'b0));
        chk({tg, " B.rd2"},  b_rd2,          m_read(int'(rr2), 1'b0));
        chk({tg, " B.busy1"}, 32'(b_b1),     32'(m_busy(int'(rr1), 1'b0)));
        chk({tg, " B.cnt"},  32'(b_cnt),     32'(m_cnt()));
    endtask

    task automatic idle();
        we1 = 1'b0; wa1 = '0; d1 = '0;
        we2 = 1'b0; wa2 = '0; d2 = '0;
        cl  = 1'b0; cr  = '0;
        rr1 = '0;   rr2 = '0;
    endtask

    task automatic drive_random();
        we1 = 1'($urandom_range(1, 0)); wa1 = 5'($urandom_range(20, 0)); d1 = $urandom();
        we2 = 1'($urandom_range(1, 0)); wa2 = 5'($urandom_range(20, 0)); d2 = $urandom();
        cl  = 1'($urandom_range(1, 0)); cr  = 5'($urandom_range(20, 0));
        rr1 = 5'($urandom_range(20, 0)); rr2 = 5'($urandom_range(20, 0));
    endtask

    task automatic clock_edge();
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic          we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] d1;
        logic          we2;
        logic [AW-1:0] wa2;
        logic [DW-1:0] d2;
        logic          cl;
        logic [AW-1:0] cr;
        logic [AW-1:0] rr1;
        logic [AW-1:0] rr2;
        logic [DW-1:0] e_rd1;
        logic [DW-1:0] e_rd2;
        logic          e_b1;
        logic          e_b2;
        logic [AW:0]   e_cnt;
        logic [DW-1:0] e_nb1;
    } vec_t;

    vec_t vt [16];

    function automatic vec_t mk(int w1, int a1, int x1, int w2, int a2, int x2, int c, int ca,
                                int r1, int r2, int er1, int er2, int eb1, int eb2, int ec, int enb);
        vec_t v;
        v.we1 = 1'(w1); v.wa1 = 5'(a1); v.d1 = 32'(x1);
        v.we2 = 1'(w2); v.wa2 = 5'(a2); v.d2 = 32'(x2);
        v.cl = 1'(c); v.cr = 5'(ca); v.rr1 = 5'(r1); v.rr2 = 5'(r2);
        v.e_rd1 = 32'(er1); v.e_rd2 = 32'(er2); v.e_b1 = 1'(eb1); v.e_b2 = 1'(eb2);
        v.e_cnt = 6'(ec); v.e_nb1 = 32'(enb);
        return v;
    endfunction

    initial begin
        //            we1 wa1 d1      we2 wa2 d2      cl cr  rr1 rr2  rd1     rd2     b1 b2 cnt nb1
        vt[0]  = mk(1, 0, 7,        0, 0, 0,        0, 0,  0, 0,   0,      0,      0, 0, 0, 0);
        vt[1]  = mk(0, 0, 0,        0, 0, 0,        1, 0,  0, 0,   0,      0,      0, 0, 0, 0);
        vt[2]  = mk(0, 0, 0,        0, 0, 0,        0, 0,  0, 0,   0,      0,      0, 0, 0, 0);
        vt[3]  = mk(1, 5, 12,       0, 0, 0,        0, 0,  5, 5,   12,     12,     0, 0, 0, 0);
        vt[4]  = mk(0, 0, 0,        0, 0, 0,        0, 0,  5, 5,   12,     12,     0, 0, 0, 12);
        vt[5]  = mk(1, 9, 'hAAAA,   1, 9, 'h5555,   0, 0,  9, 9,   'h5555, 'h5555, 0, 0, 0, 0);
        vt[6]  = mk(0, 0, 0,        0, 0, 0,        0, 0,  5, 9,   12,     'h5555, 0, 0, 0, 12);
        vt[7]  = mk(0, 0, 0,        0, 0, 0,        1, 3,  3, 7,   0,      0,      0, 0, 0, 0);
        vt[8]  = mk(0, 0, 0,        0, 0, 0,        1, 7,  3, 7,   0,      0,      1, 0, 1, 0);
        vt[9]  = mk(0, 0, 0,        0, 0, 0,        1, 3,  3, 7,   0,      0,      1, 1, 2, 0);
        vt[10] = mk(0, 0, 0,        1, 3, 'h33,     0, 0,  3, 7,   'h33,   0,      0, 1, 2, 0);
        vt[11] = mk(1, 7, 'h77,     0, 0, 0,        1, 7,  3, 7,   'h33,   'h77,   0, 0, 1, 'h33);
        vt[12] = mk(0, 0, 0,        0, 0, 0,        0, 0,  7, 3,   'h77,   'h33,   1, 0, 1, 'h77);
        vt[13] = mk(1, 20, 1,       0, 0, 0,        0, 0,  20, 7,  0,      'h77,   0, 1, 1, 0);
        vt[14] = mk(0, 0, 0,        0, 0, 0,        1, 20, 20, 7,  0,      'h77,   0, 1, 1, 0);
        vt[15] = mk(0, 0, 0,        0, 0, 0,        0, 0,  20, 7,  0,      'h77,   0, 1, 1, 0);

        // Reset held while a write and a matching read are presented.
        m_reset();
        rst_n = 1'b0;
        idle();
        we1 = 1'b1; wa1 = 5'd5; d1 = 32'd12; rr1 = 5'd5;
        @(negedge clk);
        #1;
        chk("rst_hold rd1", a_rd1, 32'd0);
        chk("rst_hold cnt", 32'(a_cnt), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        rr1 = 5'd5;
        #1;
        chk("rst_rel rd1", a_rd1, 32'd0);
        chk("rst_rel B.rd1", b_rd1, 32'd0);
        chk("rst_rel cnt", 32'(a_cnt), 32'd0);
        chk("rst_rel busy1", 32'(a_b1), 32'd0);
        clock_edge();

        for (int i = 0; i < 16; i++) begin
            we1 = vt[i].we1; wa1 = vt[i].wa1; d1 = vt[i].d1;
            we2 = vt[i].we2; wa2 = vt[i].wa2; d2 = vt[i].d2;
            cl  = vt[i].cl;  cr  = vt[i].cr;
            rr1 = vt[i].rr1; rr2 = vt[i].rr2;
            #1;
            chk($sformatf("row%0d A.rd1", i), a_rd1, vt[i].e_rd1);
            chk($sformatf("row%0d A.rd2", i), a_rd2, vt[i].e_rd2);
            chk($sformatf("row%0d A.busy1", i), 32'(a_b1), 32'(vt[i].e_b1));
            chk($sformatf("row%0d A.busy2", i), 32'(a_b2), 32'(vt[i].e_b2));
            chk($sformatf("row%0d A.cnt", i), 32'(a_cnt), 32'(vt[i].e_cnt));
            chk($sformatf("row%0d B.rd1", i), b_rd1, vt[i].e_nb1);
            clock_edge();
        end

        for (int i = 0; i < 300; i++) begin
            drive_random();
            #1;
            check_model($sformatf("rnd%0d", i));
            clock_edge();
        end

        // Asynchronous reset asserted mid-cycle while writes and claims are in flight.
        drive_random();
        we1 = 1'b1; cl = 1'b1; cr = 5'd4;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst cnt", 32'(a_cnt), 32'd0);
        chk("midrst rd1", a_rd1, 32'd0);
        chk("midrst busy1", 32'(a_b1), 32'd0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        for (int i = 1; i < NR; i++) begin
            rr1 = 5'(i);
            #1;
            chk($sformatf("postrst rd1 idx%0d", i), a_rd1, 32'd0);
        end
        chk("postrst cnt", 32'(a_cnt), 32'd0);
        clock_edge();

        for (int i = 0; i < 50; i++) begin
            drive_random();
            #1;
            check_model($sformatf("rnd2_%0d", i));
            clock_edge();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
